// File: rtl/ascii_hex_parser_if.sv
// Character input stream and parsed-number result bundle for ascii_hex_parser.
interface ascii_hex_parser_if #(
   parameter int unsigned NDIGITS = 8
);
   localparam int unsigned W  = 4 * NDIGITS;
   localparam int unsigned CW = $clog2(NDIGITS + 1);

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [W-1:0]  value;
   logic          value_valid;
   logic [CW-1:0] ndigits_out;
   logic          err;
   logic          busy;

   // Character source / result consumer side
   modport master (
      output rx_data, rx_valid,
      input  value, value_valid, ndigits_out, err, busy
   );

   // Parser side
   modport slave (
      input  rx_data, rx_valid,
      output value, value_valid, ndigits_out, err, busy
   );
endinterface

// File: rtl/ascii_hex_parser.sv
// Assembles ASCII hex digit runs, closed by CR/LF/space, into a binary value.
module ascii_hex_parser #(
   parameter int unsigned NDIGITS = 8
) (
   input logic               clk,
   input logic               reset_n,
   ascii_hex_parser_if.slave bus
);
   localparam int unsigned W  = 4 * NDIGITS;
   localparam int unsigned CW = $clog2(NDIGITS + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  value_q, value_d;
   logic [CW-1:0] ndigits_q, ndigits_d;
   logic          value_valid_q, value_valid_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;

   logic          is_digit;
   logic          is_term;
   logic [3:0]    nibble;
   logic          full;

   // Classify the incoming character and decode its nibble
   always_comb begin
      is_digit = 1'b0;
      is_term  = 1'b0;
      nibble   = 4'd0;
      if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
         is_digit = 1'b1;
         nibble   = 4'(bus.rx_data - 8'h30);
      end else if (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66) begin
         is_digit = 1'b1;
         nibble   = 4'(bus.rx_data - 8'h57);
      end else if (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) begin
         is_digit = 1'b1;
         nibble   = 4'(bus.rx_data - 8'h37);
      end else if (bus.rx_data == 8'h0D || bus.rx_data == 8'h0A ||
                   bus.rx_data == 8'h20) begin
         is_term  = 1'b1;
      end
   end

   assign full = (cnt_q == CW'(NDIGITS));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state: digits open/extend a number, terminators close it, anything bad discards
   always_comb begin
      state_d = state_q;
      if (bus.rx_valid) begin
         case (state_q)
            S_IDLE: begin
               if (is_digit)     state_d = S_ACCUM;
               else if (!is_term) state_d = S_DISCARD;
            end
            S_ACCUM: begin
               if (is_term)                  state_d = S_IDLE;
               else if (!is_digit || full)   state_d = S_DISCARD;
            end
            S_DISCARD: begin
               if (is_term) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath and strobes; error paths leave value/ndigits untouched
   always_comb begin
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      value_d       = value_q;
      ndigits_d     = ndigits_q;
      value_valid_d = 1'b0;
      err_d         = 1'b0;
      busy_d        = (state_d != S_IDLE);
      if (bus.rx_valid) begin
         case (state_q)
            S_IDLE: begin
               if (is_digit) begin
                  acc_d = W'(nibble);
                  cnt_d = CW'(1);
               end else if (!is_term) begin
                  err_d = 1'b1;
               end
            end
            S_ACCUM: begin
               if (is_term) begin
                  value_d       = acc_q;
                  ndigits_d     = cnt_q;
                  value_valid_d = 1'b1;
               end else if (is_digit && !full) begin
                  acc_d = (acc_q << 4) | W'(nibble);
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q         <= '0;
         cnt_q         <= '0;
         value_q       <= '0;
         ndigits_q     <= '0;
         value_valid_q <= 1'b0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         value_q       <= value_d;
         ndigits_q     <= ndigits_d;
         value_valid_q <= value_valid_d;
         err_q         <= err_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.value       = value_q;
   assign bus.ndigits_out = ndigits_q;
   assign bus.value_valid = value_valid_q;
   assign bus.err         = err_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_ascii_hex_parser.sv
// Randomized bench for ascii_hex_parser against a digit-queue reference model.
module tb_ascii_hex_parser;
   localparam int unsigned NDIGITS = 8;

   logic clk;
   logic reset_n;

   ascii_hex_parser_if #(.NDIGITS(NDIGITS)) bus ();

   ascii_hex_parser #(.NDIGITS(NDIGITS)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 = between numbers, 1 = collecting digits, 2 = skipping a bad number
   int         m_mode;
   int         m_digs[$];
   logic [63:0] exp_value;
   int         exp_nd;
   logic       exp_vv, exp_err, exp_busy;

   string hu = "0123456789ABCDEF";
   string hl = "0123456789abcdef";
   string hexchars = "0123456789abcdefABCDEF";
   logic [7:0] bad_chars[11] = '{8'h47, 8'h67, 8'h21, 8'h00, 8'hFF, 8'h2F,
                                 8'h3A, 8'h40, 8'h60, 8'h09, 8'h0B};
   logic [7:0] term_chars[3] = '{8'h0D, 8'h0A, 8'h20};

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_digs.delete();
      exp_value = '0;
      exp_nd = 0;
      exp_vv = 1'b0;
      exp_err = 1'b0;
      exp_busy = 1'b0;
   endtask

   task automatic model_update(input logic v, input logic [7:0] ch);
      int  nib;
      bit  term;
      longint acc;
      exp_vv  = 1'b0;
      exp_err = 1'b0;
      if (v) begin
         nib = -1;
         for (int i = 0; i < 16; i++)
            if (ch == 8'(hu[i]) || ch == 8'(hl[i])) nib = i;
         term = (ch == 8'd13 || ch == 8'd10 || ch == 8'd32);
         if (m_mode == 0) begin
            if (nib >= 0) begin m_digs.delete(); m_digs.push_back(nib); m_mode = 1; end
            else if (!term) begin exp_err = 1'b1; m_mode = 2; end
         end else if (m_mode == 1) begin
            if (nib >= 0) begin
               if (m_digs.size() >= NDIGITS) begin exp_err = 1'b1; m_mode = 2; end
               else m_digs.push_back(nib);
            end else if (term) begin
               acc = 0;
               foreach (m_digs[i]) acc = acc * 16 + longint'(m_digs[i]);
               exp_value = 64'(acc);
               exp_nd = m_digs.size();
               exp_vv = 1'b1;
               m_mode = 0;
            end else begin
               exp_err = 1'b1; m_mode = 2;
            end
         end else begin
            if (term) m_mode = 0;
         end
      end
      exp_busy = (m_mode != 0);
   endtask

   task automatic compare_all();
      cmp("value", 64'(bus.value), exp_value);
      cmp("ndigits_out", 64'(bus.ndigits_out), 64'(exp_nd));
      cmp("value_valid", 64'(bus.value_valid), 64'(exp_vv));
      cmp("err", 64'(bus.err), 64'(exp_err));
      cmp("busy", 64'(bus.busy), 64'(exp_busy));
      if (bus.value_valid && bus.err) cmp("vv_err_exclusive", 64'd1, 64'd0);
   endtask

   // One cycle: present inputs after negedge, model the posedge, compare at next negedge
   task automatic step(input logic v, input logic [7:0] ch);
      bus.rx_valid = v;
      bus.rx_data  = ch;
      @(posedge clk);
      model_update(v, ch);
      @(negedge clk);
      compare_all();
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) step(1'b1, 8'(s[i]));
   endtask

   task automatic idle_cycle();
      step(1'b0, 8'($urandom_range(0, 255)));
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      cmp("rst_value", 64'(bus.value), 64'd0);
      cmp("rst_nd", 64'(bus.ndigits_out), 64'd0);
      cmp("rst_vv", 64'(bus.value_valid), 64'd0);
      cmp("rst_err", 64'(bus.err), 64'd0);
      cmp("rst_busy", 64'(bus.busy), 64'd0);
      reset_n = 1'b1;

      // "1A2b" CR
      send_str("1A2");
      cmp("busy_in_number", 64'(bus.busy), 64'd1);
      send_str("b");
      step(1'b1, 8'h0D);
      cmp("lit_1a2b_vv", 64'(bus.value_valid), 64'd1);
      cmp("lit_1a2b_value", 64'(bus.value), 64'h1A2B);
      cmp("lit_1a2b_nd", 64'(bus.ndigits_out), 64'd4);
      cmp("lit_busy_after_term", 64'(bus.busy), 64'd0);
      idle_cycle();
      cmp("lit_1a2b_held", 64'(bus.value), 64'h1A2B);
      cmp("lit_vv_one_cycle", 64'(bus.value_valid), 64'd0);

      // "DEADBEEF" space "7" LF back-to-back
      send_str("DEADBEEF ");
      cmp("lit_deadbeef", 64'(bus.value), 64'hDEADBEEF);
      cmp("lit_deadbeef_nd", 64'(bus.ndigits_out), 64'd8);
      send_str("7");
      cmp("lit_vv_gap", 64'(bus.value_valid), 64'd0);
      step(1'b1, 8'h0A);
      cmp("lit_7", 64'(bus.value), 64'h7);
      cmp("lit_7_vv", 64'(bus.value_valid), 64'd1);

      // "12G4" CR then "5" CR
      send_str("12G");
      cmp("lit_err_G", 64'(bus.err), 64'd1);
      send_str("4");
      cmp("lit_err_once", 64'(bus.err), 64'd0);
      step(1'b1, 8'h0D);
      cmp("lit_no_vv_bad", 64'(bus.value_valid), 64'd0);
      cmp("lit_value_kept", 64'(bus.value), 64'h7);
      send_str("5");
      step(1'b1, 8'h0D);
      cmp("lit_5", 64'(bus.value), 64'h5);

      // Overflow then "FF" CR
      send_str("12345678");
      cmp("lit_no_err_8", 64'(bus.err), 64'd0);
      send_str("9");
      cmp("lit_err_ovf", 64'(bus.err), 64'd1);
      step(1'b1, 8'h0D);
      cmp("lit_no_vv_ovf", 64'(bus.value_valid), 64'd0);
      send_str("FF");
      step(1'b1, 8'h0D);
      cmp("lit_ff", 64'(bus.value), 64'hFF);
      cmp("lit_ff_nd", 64'(bus.ndigits_out), 64'd2);

      // Empty terminators, then "A" gaps "B" CR
      step(1'b1, 8'h0D); step(1'b1, 8'h0A); step(1'b1, 8'h0A); step(1'b1, 8'h20);
      cmp("lit_empty_term_vv", 64'(bus.value_valid), 64'd0);
      cmp("lit_empty_term_busy", 64'(bus.busy), 64'd0);
      send_str("A");
      repeat ($urandom_range(1, 6)) idle_cycle();
      send_str("B");
      repeat ($urandom_range(1, 6)) idle_cycle();
      step(1'b1, 8'h0D);
      cmp("lit_ab", 64'(bus.value), 64'hAB);

      // Asynchronous reset mid-number
      send_str("AB");
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      cmp("arst_value", 64'(bus.value), 64'd0);
      cmp("arst_nd", 64'(bus.ndigits_out), 64'd0);
      cmp("arst_busy", 64'(bus.busy), 64'd0);
      cmp("arst_vv", 64'(bus.value_valid), 64'd0);
      cmp("arst_err", 64'(bus.err), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b1, 8'h0D);
      cmp("lit_cr_after_rst", 64'(bus.value_valid), 64'd0);
      send_str("C");
      step(1'b1, 8'h0D);
      cmp("lit_c", 64'(bus.value), 64'hC);

      // Random numbers of 0..10 characters with gaps, bad chars and mixed terminators
      for (int n = 0; n < 400; n++) begin
         int len;
         len = $urandom_range(0, 10);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 9) < 3) idle_cycle();
            if ($urandom_range(0, 19) == 0)
               step(1'b1, bad_chars[$urandom_range(0, 10)]);
            else
               step(1'b1, 8'(hexchars[$urandom_range(0, 21)]));
         end
         step(1'b1, term_chars[$urandom_range(0, 2)]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ascii_hex_parser.md
# ascii_hex_parser

Receive-side counterpart of the hex-to-ASCII display path: consumes a byte stream of ASCII characters (typically from the UART receiver) and assembles hexadecimal digit strings into a binary value. A number is a run of hex digits closed by a terminator; on the terminator the block presents the value with a one-cycle strobe. Malformed or over-long numbers raise an error strobe and are discarded up to the next terminator.

## Interface
- NDIGITS, 8, maximum hex digits per number; value width W = 4*NDIGITS
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- rx_data  input  8  ASCII character
- rx_valid  input  1  rx_data valid this cycle; one character consumed per cycle with rx_valid=1, no back-pressure
- value  output  W  last completed number, right-aligned, zero-extended; held until next completion
- value_valid  output  1  one-cycle strobe: value updated
- ndigits_out  output  $clog2(NDIGITS+1)  digit count of last completed number
- err  output  1  one-cycle strobe: invalid character or overflow detected
- busy  output  1  high while in ACCUM or DISCARD

## Operation
- Character classes: digit '0'-'9' (0x30-0x39) -> 0-9; 'a'-'f' (0x61-0x66) and 'A'-'F' (0x41-0x46) -> 10-15; terminator CR 0x0D, LF 0x0A, space 0x20; all other codes invalid.
- Internal: accumulator acc[W-1:0], digit counter cnt (0..NDIGITS), state.
- IDLE: digit -> acc = nibble, cnt = 1, go ACCUM. Terminator -> ignored (no strobe; handles CR LF pairs and repeated spaces). Invalid -> err, go DISCARD.
- ACCUM: digit with cnt < NDIGITS -> acc = {acc[W-5:0], nibble}, cnt+1. Digit with cnt = NDIGITS -> err, go DISCARD (overflow; acc not shifted). Terminator -> value = acc, ndigits_out = cnt, value_valid, go IDLE. Invalid -> err, go DISCARD.
- DISCARD: digits and invalid chars dropped silently (err fires once per bad number, not per character). Terminator -> go IDLE, no value_valid.
- Cycles with rx_valid=0: no state change in any state.
- value/ndigits_out change only on completion; error paths never alter them.
- Leading zeros count as digits ("00000000" with NDIGITS=8 is valid, value 0).

## Timing
- Reset (async assert, sync to clk by release): state IDLE, acc=0, cnt=0, value=0, ndigits_out=0, value_valid=0, err=0, busy=0. Reset mid-number discards the partial number with no strobe.
- Registered outputs: character sampled at edge k -> value/value_valid/err/busy reflect it from edge k until edge k+1 (latency 1 cycle).
- value_valid and err are never high in the same cycle; each is high exactly one cycle per event, even with back-to-back rx_valid.
- Back-to-back characters every cycle fully supported; next number may start on the cycle immediately after a terminator.
- busy goes high the cycle after the first digit/invalid char, low the cycle after the closing terminator.

## Test plan
- Reset then "1A2b" CR, one char per cycle -> value_valid one cycle after CR edge, value=0x00001A2B, ndigits_out=4, err never high; outputs held thereafter.
- NDIGITS=8, "DEADBEEF" space then "7" LF back-to-back -> strobe with 0xDEADBEEF/8, then strobe with 0x00000007/1, two separate one-cycle pulses.
- "12G4" CR -> single err pulse on cycle after 'G', no value_valid, value keeps previous number; following "5" CR yields 0x5.
- "123456789" CR (NDIGITS=8) -> err one cycle after 9th digit, no value_valid on CR; then "FF" CR -> value 0xFF.
- CR LF LF space alone, and rx_valid gaps of random length inside "A" ... "B" CR -> no strobes for empty terminators; gaps do not affect result, value 0xAB.
- Assert reset_n low asynchronously after "AB" (mid-cycle) -> all outputs 0 immediately; after release, CR alone -> no strobe; "C" CR -> value 0xC.
